// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared types: cache line word and arbiter FSM state
package lc3b_types;

  typedef logic [127:0] lc3b_line;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_I = 2'd1,
    OWN_D = 2'd2
  } arb_state_t;

  localparam logic [7:0] WAIT_CNT_MAX = 8'hFF;

  // Saturating increment so a starved ifetch count never wraps back to zero
  function automatic logic [7:0] sat_inc8(input logic [7:0] val);
    return (val == WAIT_CNT_MAX) ? val : val + 8'd1;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - ifetch/data to shared memory arbiter; ARB_RR_EN selects round-robin ties
module mem_arbiter
  import lc3b_types::*;
#(
  parameter int MAX_WAIT = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [11:0]    if_adr,
  input  logic           if_stb,
  input  logic           if_cyc,
  output logic           if_ack,
  output lc3b_line       if_dat_s,
  input  logic [11:0]    d_adr,
  input  lc3b_line       d_dat_m,
  input  logic [15:0]    d_sel,
  input  logic           d_we,
  input  logic           d_stb,
  input  logic           d_cyc,
  output logic           d_ack,
  output lc3b_line       d_dat_s,
  output logic [11:0]    m_adr,
  output lc3b_line       m_dat_m,
  output logic [15:0]    m_sel,
  output logic           m_we,
  output logic           m_stb,
  output logic           m_cyc,
  input  logic           m_ack,
  input  lc3b_line       m_dat_s,
  output logic [1:0]     grant
);

  localparam logic [7:0] LP_MAX_WAIT = 8'(MAX_WAIT);

  arb_state_t r_state;
  arb_state_t w_next_state;
  logic [7:0] r_wait_cnt;
  logic       r_last_d;
  logic       w_if_req;
  logic       w_d_req;
  logic       w_pick_d;
  logic       w_pick_i;

  assign w_if_req = if_stb & if_cyc;
  assign w_d_req  = d_stb & d_cyc;

`ifdef ARB_RR_EN
  // Tie goes to whoever was not granted last; the starvation counter is ignored
  assign w_pick_d = w_d_req & (~w_if_req | ~r_last_d);
`else
  // Data wins ties unless ifetch has been passed over MAX_WAIT times
  assign w_pick_d = w_d_req & ~(w_if_req & (r_wait_cnt >= LP_MAX_WAIT));
`endif
  assign w_pick_i = w_if_req & ~w_pick_d;

  // State, starvation counter and last-granted flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_wait_cnt <= 8'd0;
      r_last_d   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (r_state == IDLE) begin
        if (w_pick_d) begin
          r_last_d <= 1'b1;
          if (w_if_req) r_wait_cnt <= sat_inc8(r_wait_cnt);
        end else if (w_pick_i) begin
          r_last_d   <= 1'b0;
          r_wait_cnt <= 8'd0;
        end
      end
    end
  end

  // Next state: owner is released on ack or when it withdraws its request
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_pick_d)      w_next_state = OWN_D;
        else if (w_pick_i) w_next_state = OWN_I;
      end
      OWN_I: if (m_ack || !w_if_req) w_next_state = IDLE;
      OWN_D: if (m_ack || !w_d_req)  w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  assign if_dat_s = m_dat_s;
  assign d_dat_s  = m_dat_s;

  // Route the owning master onto the shared port and steer ack back to it
  always_comb begin
    m_adr   = 12'd0;
    m_dat_m = '0;
    m_sel   = 16'd0;
    m_we    = 1'b0;
    m_stb   = 1'b0;
    m_cyc   = 1'b0;
    if_ack  = 1'b0;
    d_ack   = 1'b0;
    grant   = 2'b00;
    case (r_state)
      OWN_I: begin
        m_adr  = if_adr;
        m_sel  = 16'hFFFF;
        m_stb  = if_stb;
        m_cyc  = if_cyc;
        if_ack = m_ack;
        grant  = 2'b01;
      end
      OWN_D: begin
        m_adr   = d_adr;
        m_dat_m = d_dat_m;
        m_sel   = d_sel;
        m_we    = d_we;
        m_stb   = d_stb;
        m_cyc   = d_cyc;
        d_ack   = m_ack;
        grant   = 2'b10;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL expose parameter MAX_WAIT, default 8, meaning the number of cycles a waiting ifetch request may be passed over before it is force-granted (range 1..255).
REQ-002 SHALL have port clk  input  1  system clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports if_adr / if_stb / if_cyc  input  12/1/1  ifetch master line address, strobe and cycle (read-only).
REQ-005 SHALL have ports if_ack / if_dat_s  output  1/128  ifetch acknowledge and read line.
REQ-006 SHALL have ports d_adr / d_dat_m / d_sel / d_we / d_stb / d_cyc  input  12/128/16/1/1/1  data master.
REQ-007 SHALL have ports d_ack / d_dat_s  output  1/128  data acknowledge and read line.
REQ-008 SHALL have ports m_adr / m_dat_m / m_sel / m_we / m_stb / m_cyc  output  12/128/16/1/1/1  shared downstream memory port.
REQ-009 SHALL have ports m_ack / m_dat_s  input  1/128  downstream acknowledge and read line.
REQ-010 SHALL have port grant  output  2  current owner, one-hot: bit0 = ifetch, bit1 = data.

Function
REQ-011 SHALL implement FSM states IDLE, OWN_I and OWN_D, held in a registered state.
REQ-012 Request definitions SHALL be if_req = if_stb & if_cyc and d_req = d_stb & d_cyc.
REQ-013 IDLE SHALL select the next owner per REQ-022/023 and move to OWN_I or OWN_D on the next edge; with no request it SHALL stay in IDLE.
REQ-014 While in OWN_x, all m_* outputs SHALL be driven combinationally from master x; in IDLE, m_stb = m_cyc = m_we = 0 and m_sel = 0.
REQ-015 x_ack SHALL equal m_ack only while in OWN_x and SHALL be 0 otherwise; x_dat_s SHALL equal m_dat_s in all states.
REQ-016 On m_ack in OWN_x the FSM SHALL return to IDLE on the next edge, giving one dead cycle between transactions.
REQ-017 If the owner deasserts its request before m_ack, the FSM SHALL abandon the transaction and return to IDLE.
REQ-018 Grant-to-downstream latency SHALL be exactly one cycle: a request seen in IDLE at edge N drives m_stb from cycle N+1.
REQ-019 Counter wait_cnt (8 bits) SHALL increment each IDLE-exit cycle in which if_req = 1 and OWN_D is chosen, and SHALL clear when OWN_I is entered.
REQ-020 wait_cnt SHALL saturate at 255 and never wrap.
REQ-021 grant SHALL be 2'b01 in OWN_I, 2'b10 in OWN_D and 2'b00 in IDLE.

Configuration
REQ-022 Without ARB_RR_EN, arbitration SHALL be fixed priority: data wins ties, except that ifetch wins when wait_cnt >= MAX_WAIT.
REQ-023 With ARB_RR_EN defined, ties SHALL go to the master not granted last (flag last_d, reset value 0, so data wins the first tie), and wait_cnt and MAX_WAIT SHALL have no effect.

Reset
REQ-024 While rst_n = 0: state = IDLE, wait_cnt = 0, last_d = 0, grant = 0, if_ack = d_ack = 0, m_stb = m_cyc = m_we = 0.
REQ-025 Reset asserted mid-transaction SHALL abandon it immediately; no ack SHALL be forwarded after reset assertion.

Structure
REQ-026 The enum arb_state_t (IDLE, OWN_I, OWN_D) SHALL live in lc3b_types beside lc3b_line; the 128-bit data ports SHALL use lc3b_line.
REQ-027 The module SHALL be a single module with no sub-modules; next-state logic and output muxing are separate always blocks.

Verification
REQ-028 Single ifetch: if_req with if_adr = 12'h010 in IDLE, m_ack 3 cycles later -> m_adr = 12'h010, if_ack pulses 1 cycle, d_ack stays 0, then IDLE.
REQ-029 Tie, fixed mode: both requests at once -> OWN_D first (m_we = d_we, m_sel = d_sel = 16'h0003), then dead cycle, then OWN_I.
REQ-030 Starvation, fixed mode, MAX_WAIT = 2: d_req held continuously with if_req -> exactly 2 data grants, then OWN_I; wait_cnt returns to 0.
REQ-031 ARB_RR_EN: both requests held for 4 transactions -> grant sequence 10, 01, 10, 01.
REQ-032 Abort: OWN_D entered, d_stb dropped before m_ack -> IDLE next cycle, d_ack never asserted, m_stb = 0.
REQ-033 Reset during OWN_I, with m_ack arriving in the same cycle -> if_ack = 0 and state = IDLE; after release the next request is granted with one-cycle latency.
